// File: rtl/pot_scan_seq.sv
// -----------------------------------------------------------------------------
// pot_scan_seq
//
// Command sequencer that sits in front of the SPI master talking to the
// slide-potentiometer A2D. It walks channels 0..NUM_CH-1 in round-robin order.
// For each channel it issues a convert command, waits GAP_CYC idle cycles for
// the conversion to finish, then issues a read command. The low 12 bits of
// the read response are stored per channel and announced with a one-cycle
// result pulse.
//
// Handshake with the SPI master:
//   snd is a one-cycle start strobe, and cmd is valid whenever snd=1.
//   A transaction is complete only on a rising edge of done. done is a level
//   that stays high from the end of a transaction until the next start, so a
//   done that is already high is never taken as completion. resp is sampled
//   on the done rising edge.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   en         scan enable (level); sampled only in IDLE and STORE
//   snd, cmd   start pulse / command word to SPI master
//   done, resp SPI master completion level / received word
//   res_vld    one-cycle pulse, new result stored (res_ch, res_data)
//   pot_vals   all stored results, channel k at [12k+11:12k]
//   scan_done  one-cycle pulse together with res_vld of channel NUM_CH-1
// -----------------------------------------------------------------------------
module pot_scan_seq #(
    parameter int NUM_CH  = 5,
    parameter int GAP_CYC = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   snd,
    output logic [15:0]            cmd,
    input  logic                   done,
    input  logic [15:0]            resp,
    output logic                   res_vld,
    output logic [2:0]             res_ch,
    output logic [11:0]            res_data,
    output logic [NUM_CH*12-1:0]   pot_vals,
    output logic                   scan_done
);

    localparam int         GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_CV = 3'd1,
        WAIT_CV = 3'd2,
        GAP     = 3'd3,
        SEND_RD = 3'd4,
        WAIT_RD = 3'd5,
        STORE   = 3'd6
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      ch;
    logic [2:0]      ch_nxt;
    logic [GW-1:0]   gap_cnt;
    logic            done_q;
    logic            done_rise;
    logic [11:0]     rd_word;

    // The upper response nibble carries no conversion data.
    logic            unused_resp_hi;
    assign unused_resp_hi = &{1'b0, resp[15:12]};

    assign done_rise = done & ~done_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = SEND_CV;
            SEND_CV: state_nxt = WAIT_CV;
            WAIT_CV: if (done_rise) state_nxt = GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = SEND_RD;
            SEND_RD: state_nxt = WAIT_RD;
            WAIT_RD: if (done_rise) state_nxt = STORE;
            STORE:   state_nxt = en ? SEND_CV : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        snd    = 1'b0;
        ch_nxt = ch;
        if (state == SEND_CV || state == SEND_RD) begin
            snd = 1'b1;
        end
        if (state == STORE) begin
            ch_nxt = (ch == LAST_CH) ? 3'd0 : ch + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            gap_cnt   <= '0;
            ch        <= 3'd0;
            cmd       <= 16'h0000;
            rd_word   <= 12'h000;
            res_vld   <= 1'b0;
            res_ch    <= 3'd0;
            res_data  <= 12'h000;
            scan_done <= 1'b0;
            pot_vals  <= '0;
        end else begin
            done_q <= done;

            if (state == WAIT_CV && done_rise) begin
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end

            // Load cmd with the channel that the coming SEND state will
            // use; ch_nxt already reflects the STORE increment.
            if (state_nxt == SEND_CV || state_nxt == SEND_RD) begin
                cmd <= {2'b00, ch_nxt, 11'h000};
            end

            // resp is only guaranteed valid at the done rising edge.
            if (state == WAIT_RD && done_rise) begin
                rd_word <= resp[11:0];
            end

            res_vld   <= (state == STORE);
            scan_done <= (state == STORE) && (ch == LAST_CH);
            if (state == STORE) begin
                res_ch   <= ch;
                res_data <= rd_word;
            end

            ch <= ch_nxt;

            for (int k = 0; k < NUM_CH; k++) begin
                if (state == STORE && ch == 3'(k)) begin
                    pot_vals[12*k +: 12] <= rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_pot_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_pot_scan_seq
//
// Directed bench for pot_scan_seq (NUM_CH=5, GAP_CYC=32). A behavioural SPI
// master answers each snd after a fixed latency, optionally holding the old
// done level high for a few cycles after the start (stale-done case). A
// monitor records every snd command and every result pulse; the main
// sequence compares them against hand-written expected queues.
// -----------------------------------------------------------------------------
module tb_pot_scan_seq;

    localparam int NUM_CH  = 5;
    localparam int GAP_CYC = 32;
    localparam int LAT     = 3;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic                 snd;
    logic [15:0]          cmd;
    logic                 done;
    logic [15:0]          resp;
    logic                 res_vld;
    logic [2:0]           res_ch;
    logic [11:0]          res_data;
    logic [NUM_CH*12-1:0] pot_vals;
    logic                 scan_done;

    pot_scan_seq #(.NUM_CH(NUM_CH), .GAP_CYC(GAP_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .snd       (snd),
        .cmd       (cmd),
        .done      (done),
        .resp      (resp),
        .res_vld   (res_vld),
        .res_ch    (res_ch),
        .res_data  (res_data),
        .pot_vals  (pot_vals),
        .scan_done (scan_done)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- SPI master model + monitor ----------------
    logic [15:0] resp_val [NUM_CH];
    logic [15:0] conv_resp;
    int          stale_hold;

    logic [15:0] snd_cmd_q [$];
    logic [15:0] res_q [$];       // {scan_done, res_ch, res_data}
    int          gap_q [$];
    int          rise_cnt    = 0;
    int          overlap_cnt = 0;

    logic        outstanding = 1'b0;
    logic        phase_rd    = 1'b0;
    logic        cur_rd      = 1'b0;
    logic [15:0] cur_cmd     = 16'h0;
    int          hold        = 0;
    int          busy        = 0;
    int          last_cv_rise = 0;

    always @(negedge clk) begin
        if (rst) begin
            done        = 1'b0;
            outstanding = 1'b0;
            phase_rd    = 1'b0;
            hold        = 0;
            busy        = 0;
        end else if (snd) begin
            if (outstanding) overlap_cnt++;
            outstanding = 1'b1;
            cur_cmd     = cmd;
            cur_rd      = phase_rd;
            phase_rd    = ~phase_rd;
            snd_cmd_q.push_back(cmd);
            if (cur_rd) gap_q.push_back(cyc - last_cv_rise);
            hold = stale_hold;
            busy = LAT;
            if (hold == 0) done = 1'b0;
        end else if (outstanding) begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) done = 1'b0;
            end else if (busy > 1) begin
                busy--;
            end else begin
                done        = 1'b1;
                outstanding = 1'b0;
                resp        = cur_rd ? resp_val[cur_cmd[13:11]] : conv_resp;
                rise_cnt++;
                if (!cur_rd) last_cv_rise = cyc;
            end
        end
        if (res_vld) res_q.push_back({scan_done, res_ch, res_data});
    end

    // ---------------- check / wait helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // which: 0 = results, 1 = snd commands, 2 = done rises
    task automatic wait_cnt(input int which, input int n, input int budget, input string tag);
        int k;
        int cur;
        k = 0;
        cur = (which == 0) ? res_q.size() : (which == 1) ? snd_cmd_q.size() : rise_cnt;
        while (cur < n && k < budget) begin
            step(1);
            k++;
            cur = (which == 0) ? res_q.size() : (which == 1) ? snd_cmd_q.size() : rise_cnt;
        end
        chk(tag, 64'(cur >= n), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_snd"},       64'(snd),       64'd0);
        chk({pfx, "_cmd"},       64'(cmd),       64'd0);
        chk({pfx, "_res_vld"},   64'(res_vld),   64'd0);
        chk({pfx, "_res_ch"},    64'(res_ch),    64'd0);
        chk({pfx, "_res_data"},  64'(res_data),  64'd0);
        chk({pfx, "_pot_vals"},  64'(pot_vals),  64'd0);
        chk({pfx, "_scan_done"}, 64'(scan_done), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    logic [15:0] exp_cmd_q [$];
    logic [15:0] exp_res_q [$];
    int          snd_before;

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        done       = 1'b0;
        resp       = 16'h0;
        stale_hold = 0;
        conv_resp  = 16'hF5A3;
        resp_val[0] = 16'hF5A3;
        for (int k = 1; k < NUM_CH; k++) resp_val[k] = 16'h0100 + 16'(k);

        // Reset state
        step(3);
        chk_reset_outputs("reset");

        // First channel: cmd 0000 twice, result 5A3
        rst = 1'b0;
        en  = 1'b1;
        wait_cnt(0, 1, 2000, "wait_first_res");
        chk("first_pot0", 64'(pot_vals[11:0]), 64'h5A3);
        chk("first_res_data", 64'(res_q.size() > 0 ? res_q[0] : 16'hFFFF), 64'h05A3);

        // Full scan through wrap to channel 0
        resp_val[0] = 16'h0100;
        conv_resp   = 16'hDEAD;
        wait_cnt(0, 6, 4000, "wait_wrap_res");
        chk("scan_pot_vals", 64'(pot_vals), 64'h104_103_102_101_100);

        // Drop en during WAIT_CV of channel 2 (snd index 14)
        wait_cnt(1, 15, 2000, "wait_ch2_cv_snd");
        en = 1'b0;
        wait_cnt(0, 8, 2000, "wait_ch2_res");
        step(20);
        chk("idle_snd_count", 64'(snd_cmd_q.size()), 64'd16);
        chk("idle_snd_low", 64'(snd), 64'd0);
        en = 1'b1;
        wait_cnt(1, 17, 200, "wait_resume_snd");
        chk("resume_cmd", 64'(snd_cmd_q.size() > 16 ? snd_cmd_q[16] : 16'hFFFF), 64'h1800);

        // Reset during GAP of channel 1 (convert is snd index 22)
        wait_cnt(2, 23, 3000, "wait_ch1_cv_rise");
        step(5);
        rst = 1'b1;
        step(1);
        chk_reset_outputs("midrst");
        step(1);
        rst        = 1'b0;
        stale_hold = 4;
        snd_before = snd_cmd_q.size();
        chk("midrst_snd_count", 64'(snd_before), 64'd23);
        wait_cnt(1, 24, 200, "wait_post_rst_snd");
        chk("post_rst_cmd", 64'(snd_cmd_q.size() > 23 ? snd_cmd_q[23] : 16'hFFFF), 64'h0000);

        // Stale done level: channels 0 and 1 each stored exactly once
        wait_cnt(0, 13, 3000, "wait_stale_res");
        step(1);
        chk("stale_res_count", 64'(res_q.size()), 64'd13);
        chk("stale_pot_vals", 64'(pot_vals), 64'h000_000_000_101_100);

        // Command sequence
        exp_cmd_q = '{16'h0000, 16'h0000, 16'h0800, 16'h0800, 16'h1000, 16'h1000,
                      16'h1800, 16'h1800, 16'h2000, 16'h2000, 16'h0000, 16'h0000,
                      16'h0800, 16'h0800, 16'h1000, 16'h1000, 16'h1800, 16'h1800,
                      16'h2000, 16'h2000, 16'h0000, 16'h0000, 16'h0800,
                      16'h0000, 16'h0000, 16'h0800, 16'h0800};
        chk("cmd_count_min", 64'(snd_cmd_q.size() >= exp_cmd_q.size()), 64'd1);
        for (int i = 0; i < exp_cmd_q.size() && i < snd_cmd_q.size(); i++)
            chk($sformatf("cmd[%0d]", i), 64'(snd_cmd_q[i]), 64'(exp_cmd_q[i]));

        // Result pulses {scan_done, res_ch, res_data}
        exp_res_q = '{{1'b0, 3'd0, 12'h5A3}, {1'b0, 3'd1, 12'h101}, {1'b0, 3'd2, 12'h102},
                      {1'b0, 3'd3, 12'h103}, {1'b1, 3'd4, 12'h104}, {1'b0, 3'd0, 12'h100},
                      {1'b0, 3'd1, 12'h101}, {1'b0, 3'd2, 12'h102}, {1'b0, 3'd3, 12'h103},
                      {1'b1, 3'd4, 12'h104}, {1'b0, 3'd0, 12'h100}, {1'b0, 3'd0, 12'h100},
                      {1'b0, 3'd1, 12'h101}};
        for (int i = 0; i < exp_res_q.size() && i < res_q.size(); i++)
            chk($sformatf("res[%0d]", i), 64'(res_q[i]), 64'(exp_res_q[i]));

        // Conversion gap: rise cycle to read snd cycle is GAP_CYC+1
        chk("gap_count_min", 64'(gap_q.size() >= 13), 64'd1);
        for (int i = 0; i < gap_q.size(); i++)
            chk($sformatf("gap[%0d]", i), 64'(gap_q[i]), 64'(GAP_CYC + 1));

        chk("snd_overlap", 64'(overlap_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
